// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and single-instruction fetch sequencer.
// Fetches one 32-bit word per PC, waits for retirement, then loads the next PC; halts sticky on fault.
module pc_fetch_unit #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [63:0]      StartPC,
    input  logic [63:0]      NextPC,
    output logic [63:0]      CurrentPC,
    output logic             IMemReq,
    output logic [63:0]      IMemAddr,
    input  logic             IMemAck,
    input  logic [31:0]      IMemData,
    output logic [31:0]      Instruction,
    output logic             InstrValid,
    input  logic             InstrDone,
    output logic             Fault,
    output logic [1:0]       FaultCode,
    output logic [CNT_W-1:0] RetiredCount
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    // Counter only has to reach ACK_TIMEOUT-1: the expiring cycle is the last FETCH cycle itself.
    localparam int              TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    logic [1:0]       state_reg,  state_next;
    logic [63:0]      pc_reg,     pc_next;
    logic [31:0]      instr_reg,  instr_next;
    logic [1:0]       code_reg,   code_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             to_expired;

    generate
        if (ACK_TIMEOUT != 0) begin : g_timeout
            assign to_expired = (to_cnt_reg == TO_LAST);
        end else begin : g_no_timeout
            assign to_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        code_next   = code_reg;
        cnt_next    = cnt_reg;
        to_cnt_next = to_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                to_cnt_next = '0;
                if (pc_reg[1:0] != 2'b00) begin
                    state_next = S_FAULT;
                    code_next  = FC_MISALIGN;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // An ack arriving in the expiring cycle still completes the fetch.
                if (IMemAck) begin
                    instr_next  = IMemData;
                    to_cnt_next = '0;
                    state_next  = S_ISSUE;
                end else if (to_expired) begin
                    state_next = S_FAULT;
                    code_next  = FC_TIMEOUT;
                end else if (ACK_TIMEOUT != 0) begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            S_ISSUE: begin
                if (InstrDone) begin
                    pc_next  = NextPC;
                    cnt_next = cnt_reg + CNT_W'(1);
                    // The bad PC is still loaded so CurrentPC reports the offending address.
                    if (NextPC[1:0] != 2'b00) begin
                        state_next = S_FAULT;
                        code_next  = FC_MISALIGN;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg  <= S_IDLE;
            pc_reg     <= StartPC;
            instr_reg  <= '0;
            code_reg   <= FC_NONE;
            cnt_reg    <= '0;
            to_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            code_reg   <= code_next;
            cnt_reg    <= cnt_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    assign CurrentPC    = pc_reg;
    assign IMemAddr     = pc_reg;
    assign IMemReq      = (state_reg == S_FETCH);
    assign InstrValid   = (state_reg == S_ISSUE);
    assign Fault        = (state_reg == S_FAULT);
    assign FaultCode    = code_reg;
    assign Instruction  = instr_reg;
    assign RetiredCount = cnt_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected fetch/issue/fault events,
// a negedge monitor pops and compares them as the DUT presents each one.
module tb_pc_fetch_unit;

    localparam int ACK_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int EV_FETCH    = 0;
    localparam int EV_ISSUE    = 1;
    localparam int EV_FAULT    = 2;

    logic             clk = 1'b0;
    logic             Reset;
    logic [63:0]      StartPC;
    logic [63:0]      NextPC;
    logic [63:0]      CurrentPC;
    logic             IMemReq;
    logic [63:0]      IMemAddr;
    logic             IMemAck;
    logic [31:0]      IMemData;
    logic [31:0]      Instruction;
    logic             InstrValid;
    logic             InstrDone;
    logic             Fault;
    logic [1:0]       FaultCode;
    logic [CNT_W-1:0] RetiredCount;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK         (clk),
        .Reset       (Reset),
        .StartPC     (StartPC),
        .NextPC      (NextPC),
        .CurrentPC   (CurrentPC),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemAck     (IMemAck),
        .IMemData    (IMemData),
        .Instruction (Instruction),
        .InstrValid  (InstrValid),
        .InstrDone   (InstrDone),
        .Fault       (Fault),
        .FaultCode   (FaultCode),
        .RetiredCount(RetiredCount)
    );

    typedef struct {
        int          kind;
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass    = 0;
    int          n_total   = 0;
    int          exp_cnt   = 0;
    logic [63:0] exp_pc    = '0;
    logic [31:0] exp_instr = '0;
    bit          prev_req  = 1'b0;
    bit          prev_val  = 1'b0;
    bit          prev_flt  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic push(input int kind, input logic [63:0] pc, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.pc   = pc;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got event kind %0d, expected none", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        case (kind)
            EV_FETCH: begin
                $display("txn fetch  addr=0x%0h", IMemAddr);
                chk("fetch_addr", IMemAddr, e.pc);
            end
            EV_ISSUE: begin
                $display("txn issue  pc=0x%0h instr=0x%08h", CurrentPC, Instruction);
                chk("issue_instr", 64'(Instruction), 64'(e.data));
                chk("issue_pc", CurrentPC, e.pc);
            end
            default: begin
                $display("txn fault  pc=0x%0h code=%02b", CurrentPC, FaultCode);
                chk("fault_code", 64'(FaultCode), 64'(e.data[1:0]));
                chk("fault_pc", CurrentPC, e.pc);
            end
        endcase
    endtask

    // Monitor: a rising IMemReq, InstrValid or Fault is one DUT transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (IMemReq === 1'b1 && !prev_req) expect_event(EV_FETCH);
            if (InstrValid === 1'b1 && !prev_val) expect_event(EV_ISSUE);
            if (Fault === 1'b1 && !prev_flt) expect_event(EV_FAULT);
            prev_req = (IMemReq === 1'b1);
            prev_val = (InstrValid === 1'b1);
            prev_flt = (Fault === 1'b1);
        end
    end

    task automatic do_reset(input logic [63:0] spc);
        Reset     = 1'b1;
        StartPC   = spc;
        IMemAck   = 1'b0;
        InstrDone = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 64'(IMemReq), 64'd0);
        chk("rst_valid", 64'(InstrValid), 64'd0);
        chk("rst_fault", 64'(Fault), 64'd0);
        chk("rst_code", 64'(FaultCode), 64'd0);
        chk("rst_count", 64'(RetiredCount), 64'd0);
        chk("rst_instr", 64'(Instruction), 64'd0);
        chk("rst_pc", CurrentPC, spc);
        exp_cnt = 0;
        exp_pc  = spc;
        if (spc[1:0] != 2'b00) push(EV_FAULT, spc, 32'd1);
        else push(EV_FETCH, spc, 32'd0);
        Reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(InstrValid), 64'd0);
    endtask

    task automatic fetch_ack(input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            IMemAck = 1'b0;
            @(negedge clk);
            chk("req_held", 64'(IMemReq), 64'd1);
            chk("addr_held", IMemAddr, exp_pc);
        end
        push(EV_ISSUE, exp_pc, data);
        exp_instr = data;
        IMemAck   = 1'b1;
        IMemData  = data;
        @(negedge clk);
        IMemAck  = 1'b0;
        IMemData = 32'hDEAD_BEEF;
        chk("ack_to_issue", 64'(InstrValid), 64'd1);
    endtask

    task automatic retire(input int waits, input logic [63:0] npc);
        for (int i = 0; i < waits; i++) begin
            InstrDone = 1'b0;
            @(negedge clk);
            chk("valid_held", 64'(InstrValid), 64'd1);
            chk("instr_held", 64'(Instruction), 64'(exp_instr));
        end
        exp_cnt++;
        if (npc[1:0] != 2'b00) push(EV_FAULT, npc, 32'd1);
        else push(EV_FETCH, npc, 32'd0);
        InstrDone = 1'b1;
        NextPC    = npc;
        @(negedge clk);
        InstrDone = 1'b0;
        NextPC    = 64'h5555_0000;
        exp_pc    = npc;
        chk("retired_count", 64'(RetiredCount), 64'(exp_cnt % (1 << CNT_W)));
        chk("pc_loaded", CurrentPC, npc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset     = 1'b1;
        StartPC   = '0;
        NextPC    = '0;
        IMemAck   = 1'b0;
        IMemData  = '0;
        InstrDone = 1'b0;

        // Reset, first fetch, retire to the sequential PC
        do_reset(64'h1000);
        fetch_ack(0, 32'h8B02_0020);
        retire(0, 64'h1004);

        // Wait-state acks, then a branch backwards
        fetch_ack(3, 32'h1111_1111);
        retire(1, 64'h0FF8);

        // Misaligned NextPC faults, stray handshakes have no effect
        fetch_ack(0, 32'h2222_2222);
        retire(0, 64'h1006);
        for (int i = 0; i < 3; i++) begin
            IMemAck   = 1'b1;
            IMemData  = 32'h3333_3333;
            InstrDone = 1'b1;
            NextPC    = 64'h4000;
            @(negedge clk);
            chk("flt_sticky", 64'(Fault), 64'd1);
            chk("flt_code_held", 64'(FaultCode), 64'd1);
            chk("flt_pc_held", CurrentPC, 64'h1006);
            chk("flt_no_req", 64'(IMemReq), 64'd0);
            chk("flt_no_valid", 64'(InstrValid), 64'd0);
            chk("flt_count_held", 64'(RetiredCount), 64'd3);
        end
        IMemAck   = 1'b0;
        InstrDone = 1'b0;

        // Fetch timeout after ACK_TIMEOUT cycles with no ack
        do_reset(64'h3000);
        push(EV_FAULT, 64'h3000, 32'd2);
        for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
            @(negedge clk);
            chk("no_fault_yet", 64'(Fault), 64'd0);
        end
        @(negedge clk);
        chk("timeout_fault", 64'(Fault), 64'd1);
        chk("timeout_code", 64'(FaultCode), 64'd2);

        // Ack in the expiring cycle wins
        do_reset(64'h3000);
        fetch_ack(ACK_TIMEOUT - 1, 32'hA5A5_5A5A);
        chk("late_ack_no_fault", 64'(Fault), 64'd0);

        // Reset mid-ISSUE, then 17 back-to-back retires wrap the 4-bit counter
        do_reset(64'h2000);
        for (int i = 0; i < 17; i++) begin
            fetch_ack(0, 32'hC000_0000 + 32'(i));
            retire(0, 64'h2000 + 64'(4 * (i + 1)));
        end
        chk("count_wrapped", 64'(RetiredCount), 64'd1);

        // Misaligned StartPC faults straight out of IDLE
        do_reset(64'h3002);
        chk("idle_misalign_fault", 64'(Fault), 64'd1);
        chk("idle_misalign_code", 64'(FaultCode), 64'd1);
        chk("idle_misalign_req", 64'(IMemReq), 64'd0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
